cc_line_serializer_p: RTL
=========================

Name: cc_line_serializer_p

Overview:
Parametrised cache-line serializer for the cache controller read-response path. It pops one line entry from a first-word-fall-through FIFO and emits it as BEATS data beats on a valid/ready read channel toward the interconnect. Each entry selects its own burst order: critical-word-first wrapping, or linear from beat 0. Back-to-back lines stream with no idle cycle between them.

Parameters:
DATA_W, 64, beat width in bits
BEATS, 8, beats per line; power of 2, >=2
IDX_W, $clog2(BEATS), derived; beat-index width
ENTRY_W, IDX_W+1+BEATS*DATA_W, derived; FIFO entry width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
fifo_empty_i  in  1  FIFO empty
fifo_rdata_i  in  ENTRY_W  head entry {idx[IDX_W-1:0], wrap, line}; beat k = line[k*DATA_W +: DATA_W]
fifo_rden_o  out  1  pop strobe; head entry consumed this cycle
rdata_o  out  DATA_W  beat data
rlast_o  out  1  final beat of line
rvalid_o  out  1  beat valid
rready_i  in  1  downstream ready
busy_o  out  1  line held in buffer

Behaviour:
- Reset (rst_n=0 at posedge clk, synchronous, active-low): state=IDLE, cnt=0, start=0, buffer cleared. Outputs: rvalid_o=0, rlast_o=0, busy_o=0, fifo_rden_o=0, rdata_o=0.
- FIFO is FWFT: fifo_rdata_i is valid whenever fifo_empty_i=0.
- fifo_rden_o (combinational) = !fifo_empty_i && (state==IDLE || last_hs), where last_hs = rvalid_o && rready_i && rlast_o.
- On a pop, the full entry is registered: line buffer, start <= (wrap ? idx : 0), cnt <= 0, state <= SEND.
- IDLE: rvalid_o=0. Pop when FIFO is non-empty. First beat is valid the cycle after the pop (1-cycle latency).
- SEND: rvalid_o=1.
  - ptr = (start+cnt) mod BEATS, using natural IDX_W-bit wrap.
  - rdata_o = beat[ptr]; rlast_o = (cnt==BEATS-1).
- Handshake: on rvalid_o && rready_i, cnt <= cnt+1. When !rready_i, rdata_o, rlast_o and rvalid_o hold stable; once asserted, rvalid_o never drops before the beat transfers.
- Last handshake:
  - FIFO non-empty: pop the next entry in the same cycle, stay in SEND; the next line's beat 0 is valid the following cycle (zero bubble).
  - FIFO empty: go to IDLE.
- A pop never occurs in SEND except on last_hs.
- wrap=0: idx ignored; order is 0..BEATS-1.
- wrap=1, idx=0: identical order to wrap=0.
- busy_o=1 in SEND.
- Reset mid-burst: the remaining beats are dropped and the module returns to IDLE. The FIFO is not popped during reset.
- fifo_empty_i going low mid-burst has no effect until last_hs.

Optional Feature:
Macro CC_SER_PERF_EN.
- Defined: adds output ports perf_lines_o[31:0] and perf_stall_o[31:0], both 0 on reset, saturating at 0xFFFF_FFFF.
  - perf_lines_o increments on each last_hs.
  - perf_stall_o increments each cycle with rvalid_o && !rready_i.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- DATA_W=64, BEATS=8 for all cases. Beat k data = 0x1000+k.
- Wrap, critical word: idx=2, wrap=1, rready_i=1 -> beats 0x1002,0x1003,...,0x1007,0x1000,0x1001 on consecutive cycles; rlast_o only on 0x1001; first beat one cycle after fifo_rden_o.
- Linear: idx=5, wrap=0 -> beats 0x1000..0x1007 in order; rlast_o on 0x1007.
- Back-to-back: two entries queued (second uses 0x2000+k, idx=7, wrap=1) -> 16 consecutive valid cycles. The second fifo_rden_o pulse coincides with the first line's rlast_o handshake. The second line's order is 0x2007,0x2000..0x2006.
- Backpressure: rready_i low for 3 cycles on beat 3 of idx=0 -> rdata_o=0x1003 and rvalid_o=1 held for 3 cycles, no cnt advance, no pop. With CC_SER_PERF_EN, perf_stall_o=3; perf_lines_o=1 after the line completes.
- Reset mid-burst: rst_n=0 after beat 4 -> next cycle rvalid_o=0, busy_o=0. With the FIFO empty afterwards, no further beats. A later entry starts cleanly at its critical word.
- Empty FIFO: fifo_empty_i=1 for 20 cycles -> fifo_rden_o=0 and rvalid_o=0 throughout.

Source files
------------

// File: rtl/cc_line_serializer_p.sv
// Cache-line serializer: pops one FWFT FIFO entry and emits it as BEATS beats,
// wrapping from the critical word or linear. Optional counters: CC_SER_PERF_EN.
module cc_line_serializer_p #(
  parameter int DATA_W  = 64,
  parameter int BEATS   = 8,
  parameter int IDX_W   = $clog2(BEATS),
  parameter int ENTRY_W = IDX_W + 1 + BEATS * DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_empty_i,
  input  logic [ENTRY_W-1:0] fifo_rdata_i,
  output logic               fifo_rden_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic               rlast_o,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic               busy_o
`ifdef CC_SER_PERF_EN
  ,
  output logic [31:0]        perf_lines_o,
  output logic [31:0]        perf_stall_o
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(BEATS - 1);

  state_t                   state_reg, state_next;
  logic [IDX_W-1:0]         cnt_reg, cnt_next;
  logic [IDX_W-1:0]         start_reg, start_next;
  logic [BEATS*DATA_W-1:0]  line_reg, line_next;

  logic [IDX_W-1:0]         entry_idx;
  logic                     entry_wrap;
  logic [BEATS*DATA_W-1:0]  entry_line;
  logic [DATA_W-1:0]        beat [BEATS];
  logic [IDX_W-1:0]         ptr;
  logic                     sending;
  logic                     last_hs;
  logic                     pop;

  assign entry_idx  = fifo_rdata_i[ENTRY_W-1 -: IDX_W];
  assign entry_wrap = fifo_rdata_i[BEATS*DATA_W];
  assign entry_line = fifo_rdata_i[BEATS*DATA_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat[gi] = line_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Natural IDX_W-bit overflow gives the modulo-BEATS wrap.
  assign ptr     = start_reg + cnt_reg;
  assign sending = (state_reg == SEND);
  assign last_hs = sending && rready_i && (cnt_reg == LAST_CNT);
  // Gated by rst_n so the FIFO is never popped while reset is held.
  assign pop     = rst_n && !fifo_empty_i && (!sending || last_hs);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    start_next  = start_reg;
    line_next   = line_reg;
    rvalid_o    = sending;
    busy_o      = sending;
    rlast_o     = sending && (cnt_reg == LAST_CNT);
    rdata_o     = sending ? beat[ptr] : '0;
    fifo_rden_o = pop;

    if (pop) begin
      line_next  = entry_line;
      start_next = entry_wrap ? entry_idx : '0;
      cnt_next   = '0;
      state_next = SEND;
    end else if (sending && rready_i) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == LAST_CNT) state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      start_reg <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      start_reg <= start_next;
      line_reg  <= line_next;
    end
  end

`ifdef CC_SER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lines_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (last_hs && (perf_lines_o != 32'hFFFF_FFFF))
        perf_lines_o <= perf_lines_o + 32'd1;
      if (sending && !rready_i && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
